// File: rtl/riscv_mdu.sv
// Iterative RISC-V M-extension multiply/divide unit: shift-add multiply, restoring divide.
// Define MDU_FAST_MUL_EN to compute all multiplies in a single cycle instead.
module riscv_mdu #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [2:0]       op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] result_o,
    output logic             done_o,
    output logic             busy_o
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CntMax = CW'(WIDTH - 1);

    localparam logic [2:0] OpMul    = 3'b000;
    localparam logic [2:0] OpMulh   = 3'b001;
    localparam logic [2:0] OpMulhsu = 3'b010;
    localparam logic [2:0] OpMulhu  = 3'b011;
    localparam logic [2:0] OpDiv    = 3'b100;
    localparam logic [2:0] OpDivu   = 3'b101;
    localparam logic [2:0] OpRem    = 3'b110;
    localparam logic [2:0] OpRemu   = 3'b111;

    typedef enum logic [1:0] {StIdle, StCalc, StFin} state_e;

    state_e             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2:0]         op_q, op_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [2*WIDTH-1:0] p_q, p_d;
    logic               neg_q, neg_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               done_q, done_d;

    logic               a_signed, b_signed;
    logic [WIDTH-1:0]   a_abs, b_abs;
    logic               neg_acc;
    logic [WIDTH:0]     mul_sum, div_shift, div_diff;
    logic [2*WIDTH-1:0] mul_next, div_next, step, prod_fix;
    logic [WIDTH-1:0]   quo, rem, fin_res;

    always_comb begin
        a_signed = (op_i == OpMulh) || (op_i == OpMulhsu) || (op_i == OpDiv) || (op_i == OpRem);
        b_signed = (op_i == OpMulh) || (op_i == OpDiv) || (op_i == OpRem);
        a_abs    = (a_signed && a_i[WIDTH-1]) ? -a_i : a_i;
        b_abs    = (b_signed && b_i[WIDTH-1]) ? -b_i : b_i;
        unique case (op_i)
            OpMulh:   neg_acc = a_i[WIDTH-1] ^ b_i[WIDTH-1];
            OpMulhsu: neg_acc = a_i[WIDTH-1];
            OpDiv:    neg_acc = (a_i[WIDTH-1] ^ b_i[WIDTH-1]) && (b_i != '0);
            OpRem:    neg_acc = a_i[WIDTH-1];
            default:  neg_acc = 1'b0;
        endcase
    end

    // p_q holds {accumulator/remainder, multiplier/quotient}; both step one bit per cycle.
    always_comb begin
        mul_sum   = {1'b0, p_q[2*WIDTH-1:WIDTH]} + (p_q[0] ? {1'b0, b_q} : '0);
        mul_next  = {mul_sum, p_q[WIDTH-1:1]};
        div_shift = {p_q[2*WIDTH-1:WIDTH], p_q[WIDTH-1]};
        div_diff  = div_shift - {1'b0, b_q};
        if (!div_diff[WIDTH]) begin
            div_next = {div_diff[WIDTH-1:0], p_q[WIDTH-2:0], 1'b1};
        end else begin
            div_next = {div_shift[WIDTH-1:0], p_q[WIDTH-2:0], 1'b0};
        end
        step     = op_q[2] ? div_next : mul_next;
        prod_fix = neg_q ? -step : step;
        quo      = step[WIDTH-1:0];
        rem      = step[2*WIDTH-1:WIDTH];
        unique case (op_q)
            OpMul:                     fin_res = prod_fix[WIDTH-1:0];
            OpMulh, OpMulhsu, OpMulhu: fin_res = prod_fix[2*WIDTH-1:WIDTH];
            OpDiv, OpDivu:             fin_res = (b_q == '0) ? '1 : (neg_q ? -quo : quo);
            default:                   fin_res = neg_q ? -rem : rem;
        endcase
    end

`ifdef MDU_FAST_MUL_EN
    logic signed [WIDTH:0]     fast_a, fast_b;
    logic signed [2*WIDTH+1:0] fast_p;
    logic [WIDTH-1:0]          fast_res;

    always_comb begin
        fast_a   = {a_signed & a_i[WIDTH-1], a_i};
        fast_b   = {b_signed & b_i[WIDTH-1], b_i};
        fast_p   = fast_a * fast_b;
        fast_res = (op_i == OpMul) ? fast_p[WIDTH-1:0] : fast_p[2*WIDTH-1:WIDTH];
    end
`endif

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        b_d      = b_q;
        p_d      = p_q;
        neg_d    = neg_q;
        result_d = result_q;
        done_d   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (valid_i) begin
                    op_d    = op_i;
                    b_d     = b_abs;
                    p_d     = {{WIDTH{1'b0}}, a_abs};
                    neg_d   = neg_acc;
                    cnt_d   = '0;
                    state_d = StCalc;
`ifdef MDU_FAST_MUL_EN
                    if (!op_i[2]) begin
                        result_d = fast_res;
                        done_d   = 1'b1;
                        state_d  = StFin;
                    end
`endif
                end
            end
            StCalc: begin
                p_d   = step;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CntMax) begin
                    cnt_d    = '0;
                    result_d = fin_res;
                    done_d   = 1'b1;
                    state_d  = StFin;
                end
            end
            StFin:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            op_q     <= '0;
            b_q      <= '0;
            p_q      <= '0;
            neg_q    <= 1'b0;
            result_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            b_q      <= b_d;
            p_q      <= p_d;
            neg_q    <= neg_d;
            result_q <= result_d;
            done_q   <= done_d;
        end
    end

    assign ready_o  = (state_q == StIdle);
    assign busy_o   = !ready_o;
    assign done_o   = done_q;
    assign result_o = result_q;

endmodule

// File: tb/tb_riscv_mdu.sv
// Self-checking bench for riscv_mdu: vector table through a scoreboard plus
// back-to-back and reset-abort sequences. Honours MDU_FAST_MUL_EN for latency.
module tb_riscv_mdu;
    localparam int unsigned W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         valid_i;
    logic         ready_o;
    logic [2:0]   op_i;
    logic [W-1:0] a_i;
    logic [W-1:0] b_i;
    logic [W-1:0] result_o;
    logic         done_o;
    logic         busy_o;

    riscv_mdu #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .valid_i  (valid_i),
        .ready_o  (ready_o),
        .op_i     (op_i),
        .a_i      (a_i),
        .b_i      (b_i),
        .result_o (result_o),
        .done_o   (done_o),
        .busy_o   (busy_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        string       name;
    } vec_t;

    vec_t sb_q[$];
    vec_t vecs[26];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s", name);
    endtask

    function automatic int lat(input logic [2:0] op);
`ifdef MDU_FAST_MUL_EN
        return op[2] ? W + 1 : 1;
`else
        return W + 1;
`endif
    endfunction

    // Scoreboard: every done_o pulse must match the oldest outstanding request.
    always @(negedge clk) begin
        vec_t e;
        if (!rst) check("busy_eq_not_ready", 32'(busy_o), 32'(!ready_o));
        if (done_o) begin
            if (sb_q.size() == 0) begin
                fail_now("unexpected_done");
            end else begin
                e = sb_q.pop_front();
                check(e.name, result_o, e.exp);
            end
        end
    end

    task automatic wait_ready();
        int n = 0;
        while (!ready_o && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (!ready_o) fail_now("ready_timeout");
    endtask

    task automatic run_op(input vec_t v);
        int n;
        wait_ready();
        valid_i = 1'b1;
        op_i    = v.op;
        a_i     = v.a;
        b_i     = v.b;
        @(posedge clk);
        sb_q.push_back(v);
        #1;
        valid_i = 1'b0;
        op_i    = ~v.op;
        a_i     = ~v.a;
        b_i     = ~v.b;
        n = 1;
        while (!done_o && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check({v.name, "_latency"}, 32'(n), 32'(lat(v.op)));
        check({v.name, "_ready_in_fin"}, 32'(ready_o), 32'd0);
        @(posedge clk); #1;
        check({v.name, "_done_one_cycle"}, 32'(done_o), 32'd0);
        check({v.name, "_ready_after"}, 32'(ready_o), 32'd1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v1, v2;
        int   m, n_done;

        vecs[0]  = '{3'b000, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, "mul_7_m3"};
        vecs[1]  = '{3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, "mulh_min_min"};
        vecs[2]  = '{3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, "mulhu_max"};
        vecs[3]  = '{3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhsu_m1_max"};
        vecs[4]  = '{3'b100, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, "div_m7_2"};
        vecs[5]  = '{3'b110, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, "rem_m7_2"};
        vecs[6]  = '{3'b101, 32'd100,       32'd7,         32'h0000_000E, "divu_100_7"};
        vecs[7]  = '{3'b111, 32'd100,       32'd7,         32'h0000_0002, "remu_100_7"};
        vecs[8]  = '{3'b100, 32'd5,         32'd0,         32'hFFFF_FFFF, "div_5_0"};
        vecs[9]  = '{3'b111, 32'd5,         32'd0,         32'h0000_0005, "remu_5_0"};
        vecs[10] = '{3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, "div_ovf"};
        vecs[11] = '{3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, "rem_ovf"};
        vecs[12] = '{3'b000, 32'd3,         32'd4,         32'h0000_000C, "mul_3_4"};
        vecs[13] = '{3'b101, 32'd12,        32'd4,         32'h0000_0003, "divu_12_4"};
        vecs[14] = '{3'b001, 32'hFFFF_FFF9, 32'd3,         32'hFFFF_FFFF, "mulh_m7_3"};
        vecs[15] = '{3'b011, 32'h8000_0000, 32'd4,         32'h0000_0002, "mulhu_2p31_4"};
        vecs[16] = '{3'b110, 32'd7,         32'hFFFF_FFFE, 32'h0000_0001, "rem_7_m2"};
        vecs[17] = '{3'b100, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, "div_7_m2"};
        vecs[18] = '{3'b101, 32'hFFFF_FFFF, 32'd1,         32'hFFFF_FFFF, "divu_max_1"};
        vecs[19] = '{3'b110, 32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, "rem_m5_0"};
        vecs[20] = '{3'b100, 32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFF, "div_m5_0"};
        vecs[21] = '{3'b111, 32'hFFFF_FFFF, 32'h10,        32'h0000_000F, "remu_max_16"};
        vecs[22] = '{3'b010, 32'd2,         32'h8000_0000, 32'h0000_0001, "mulhsu_2_2p31"};
        vecs[23] = '{3'b001, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h3FFF_FFFF, "mulh_max_max"};
        vecs[24] = '{3'b101, 32'd5,         32'd0,         32'hFFFF_FFFF, "divu_5_0"};
        vecs[25] = '{3'b000, 32'h1234_5678, 32'h10,        32'h2345_6780, "mul_shift"};

        // Reset with a simultaneous request: reset wins, nothing accepted.
        rst     = 1'b1;
        valid_i = 1'b1;
        op_i    = 3'b101;
        a_i     = 32'd100;
        b_i     = 32'd7;
        repeat (3) @(posedge clk);
        #1;
        check("reset_ready", 32'(ready_o), 32'd1);
        check("reset_busy", 32'(busy_o), 32'd0);
        check("reset_done", 32'(done_o), 32'd0);
        check("reset_result", result_o, 32'd0);
        rst     = 1'b0;
        valid_i = 1'b0;

        foreach (vecs[i]) run_op(vecs[i]);

        // Back-to-back: valid_i held high, second request accepted as soon as IDLE returns.
        v1 = '{3'b101, 32'd100, 32'd7, 32'h0000_000E, "b2b_first"};
        v2 = '{3'b101, 32'hFFFF_FFFF, 32'd3, 32'h5555_5555, "b2b_second"};
        wait_ready();
        valid_i = 1'b1;
        op_i    = v1.op;
        a_i     = v1.a;
        b_i     = v1.b;
        @(posedge clk);
        sb_q.push_back(v1);
        sb_q.push_back(v2);
        #1;
        a_i = v2.a;
        b_i = v2.b;
        m = 1;
        while (!done_o && m < 100) begin
            @(posedge clk); #1;
            m++;
        end
        check("b2b_first_latency", 32'(m), 32'(W + 1));
        m = 0;
        do begin
            @(posedge clk); #1;
            m++;
        end while (!done_o && m < 100);
        check("b2b_spacing", 32'(m), 32'(W + 2));
        valid_i = 1'b0;
        @(posedge clk); #1;
        check("b2b_ready_after", 32'(ready_o), 32'd1);

        // Reset mid-operation: abort with no done_o, ignored operand changes while busy.
        valid_i = 1'b1;
        op_i    = 3'b101;
        a_i     = 32'd1000;
        b_i     = 32'd3;
        @(posedge clk); #1;
        a_i = 32'd5;
        b_i = 32'd1;
        repeat (9) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        check("abort_ready", 32'(ready_o), 32'd1);
        check("abort_busy", 32'(busy_o), 32'd0);
        check("abort_result", result_o, 32'd0);
        check("abort_done", 32'(done_o), 32'd0);
        rst     = 1'b0;
        valid_i = 1'b0;
        n_done  = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done_o) n_done++;
        end
        check("abort_no_done_40", 32'(n_done), 32'd0);

        run_op('{3'b110, 32'd1000, 32'd3, 32'h0000_0001, "rem_after_abort"});
        check("scoreboard_drained", 32'(sb_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/riscv_mdu.md
RISCV_MDU -- requirements
Module: riscv_mdu

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width; iteration count equals WIDTH.
REQ-002 SHALL have port clk  input  1  rising-edge clock, sole clock.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port valid_i  input  1  request valid from decode stage.
REQ-005 SHALL have port ready_o  output  1  unit idle, can accept a request.
REQ-006 SHALL have port op_i  input  3  MDU_MUL=000, MDU_MULH=001, MDU_MULHSU=010, MDU_MULHU=011, MDU_DIV=100, MDU_DIVU=101, MDU_REM=110, MDU_REMU=111 (riscv_defines).
REQ-007 SHALL have port a_i  input  WIDTH  operand rs1 (dividend / multiplicand).
REQ-008 SHALL have port b_i  input  WIDTH  operand rs2 (divisor / multiplier).
REQ-009 SHALL have port result_o  output  WIDTH  registered result.
REQ-010 SHALL have port done_o  output  1  one-cycle pulse; result_o valid in that cycle.
REQ-011 SHALL have port busy_o  output  1  operation in progress (equals !ready_o).

Function
REQ-012 SHALL implement FSM IDLE -> CALC -> FIN -> IDLE; ready_o=1 only in IDLE.
REQ-013 SHALL accept a request in a cycle where valid_i && ready_o, latching op_i, a_i, b_i; later input changes are ignored until IDLE.
REQ-014 SHALL ignore valid_i outside IDLE; no queueing, no error.
REQ-015 SHALL (accept = cycle 0) spend cycles 1..WIDTH in CALC, one shift-add (mul) or restoring shift-subtract (div) step per cycle, driven by a counter 0..WIDTH-1.
REQ-016 SHALL be in FIN in cycle WIDTH+1 (33): result_o updated, done_o=1; IDLE with ready_o=1 in cycle WIDTH+2 (34).
REQ-017 SHALL, with valid_i held high, accept the next request in cycle 34 (back-to-back spacing 34 cycles).
REQ-018 SHALL operate on magnitudes: signed operands are absolute-valued at accept; sign fixed in FIN by two's-complement negation.
REQ-019 SHALL form a 2*WIDTH product: MUL returns low half; MULH signed x signed high half; MULHSU a signed x b unsigned high half; MULHU unsigned high half.
REQ-020 SHALL for DIV/REM truncate toward zero; remainder takes the dividend's sign.
REQ-021 SHALL on divisor zero return quotient 0xFFFFFFFF (DIV, DIVU) and remainder = dividend (REM, REMU), same latency.
REQ-022 SHALL on DIV 0x80000000 / 0xFFFFFFFF return 0x80000000; REM returns 0; same latency.
REQ-023 SHALL hold result_o at the last completed value until the next FIN.
REQ-024 SHALL let rst win over a simultaneous valid_i; the request is not accepted.

Reset
REQ-025 SHALL on rst high at a rising edge go to IDLE: ready_o=1, busy_o=0, done_o=0, result_o=0, counter=0, operand/accumulator registers=0.
REQ-026 SHALL on reset mid-operation abort the operation with no done_o pulse for it, ever.

Configuration
REQ-027 SHALL, with macro MDU_FAST_MUL_EN defined, compute MUL/MULH/MULHSU/MULHU with a single-cycle 33x33 signed multiplier: IDLE -> FIN directly, done_o in cycle 1, ready_o in cycle 2.
REQ-028 SHALL, without MDU_FAST_MUL_EN, perform multiply iteratively per REQ-015/016 (done_o in cycle 33); division is iterative in both builds.

Verification
REQ-029 SHALL cover MUL a=7, b=0xFFFFFFFD -> result_o 0xFFFFFFEB, done_o only in cycle 33, ready_o in cycle 34.
REQ-030 SHALL cover MULH 0x80000000 x 0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF.
REQ-031 SHALL cover DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD; REM same -> 0xFFFFFFFF; DIVU 100/7 -> 0x0000000E; REMU -> 0x00000002.
REQ-032 SHALL cover DIV 5/0 -> 0xFFFFFFFF; REMU 5/0 -> 0x00000005; DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM -> 0x00000000.
REQ-033 SHALL cover DIVU accepted, valid_i held with new operands during busy (ignored), rst in cycle 10 -> cycle 11: ready_o=1, result_o=0, no done_o for 40 cycles unless a new request is accepted.
REQ-034 SHALL cover build with MDU_FAST_MUL_EN: MUL 3x4 -> 0x0000000C with done_o in cycle 1; DIVU 12/4 -> 0x00000003 with done_o in cycle 33.
